// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and sizing helpers for the LC3 memory-port arbiter (lc3_mem_pkg).
// The states, the operation codes and the id-width function are used by the interface, the top and the picker.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Index width for n items; a single item still needs one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Requester and memory-port bundle of the arbiter. The master modport is the arbiter view and the slave modport is the requester/memory view.
// Requests are levels held until req_done. Memory completion is a level that may stay high for several cycles.
interface lc3_mem_arbiter_if
  import lc3_mem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_rd;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic [DATA_W-1:0]         req_rdata;

  logic                      mem_rd;
  logic                      mem_wr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_din;
  logic [DATA_W-1:0]         mem_dout;
  logic                      mem_complete;

  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  modport master (
    input  req_rd, req_wr, req_addr, req_wdata, mem_dout, mem_complete,
    output req_done, req_err, req_rdata, mem_rd, mem_wr, mem_addr, mem_din,
           grant_id, busy
  );

  modport slave (
    output req_rd, req_wr, req_addr, req_wdata, mem_dout, mem_complete,
    input  req_done, req_err, req_rdata, mem_rd, mem_wr, mem_addr, mem_din,
           grant_id, busy
  );

endinterface

// File: rtl/lc3_mem_arbiter_rr_pick.sv
// Combinational winner select over the request vector. It is zero-latency and applies no backpressure.
// With LC3_MEMARB_RR_EN the search starts at an owned rotating pointer; without it the lowest index wins.
module lc3_rr_pick
  import lc3_mem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
`ifdef LC3_MEMARB_RR_EN
  input  logic               clock,
  input  logic               reset,
  input  logic               adv,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    win
);

  logic found;

  assign any = |req;

`ifdef LC3_MEMARB_RR_EN
  logic [ID_W-1:0] ptr_q;

  // First pass covers the pointer and above, and the second pass wraps to the bottom.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr_q))) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (adv) begin
      ptr_q <= ((int'(win) + 1) >= NUM_REQ) ? '0 : (win + ID_W'(1));
    end
  end
`else
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Merges NUM_REQ requesters onto one rd/wr memory port with a watchdog; LC3_MEMARB_RR_EN selects round-robin, else fixed priority.
// The strobe rises 1 cycle after grant and req_done follows mem_complete by 1 cycle. Requesters hold their level until req_done.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input logic               clock,
  input logic               reset,
  lc3_mem_arbiter_if.master bus
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam int WD_W = id_width(TIMEOUT_CYC + 1);

  state_t              state_q, state_n;
  op_t                 op_q, op_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic [ID_W-1:0]     id_q, id_n;
  logic                err_q, err_n;
  logic [WD_W-1:0]     wd_q, wd_n;

  logic [NUM_REQ-1:0]  req_vec;
  logic [NUM_REQ-1:0]  done_vec;
  logic [ID_W-1:0]     win_id;
  logic                req_any;
  logic                grant;
  logic                wd_exp;

  assign req_vec = bus.req_rd | bus.req_wr;
  assign grant   = (state_q == IDLE) && req_any;
  assign wd_exp  = (TIMEOUT_CYC != 0) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  lc3_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
`ifdef LC3_MEMARB_RR_EN
    .clock   (clock),
    .reset   (reset),
    .adv     (grant),
`endif
    .req     (req_vec),
    .any     (req_any),
    .win     (win_id)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      id_q    <= id_n;
      err_q   <= err_n;
      wd_q    <= wd_n;
    end
  end

  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    id_n    = id_q;
    err_n   = err_q;
    wd_n    = wd_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          // Read wins when a requester raises both rd and wr.
          op_n    = bus.req_rd[win_id] ? OP_RD : OP_WR;
          addr_n  = bus.req_addr[int'(win_id)*ADDR_W +: ADDR_W];
          wdata_n = bus.req_wdata[int'(win_id)*DATA_W +: DATA_W];
          id_n    = win_id;
          err_n   = 1'b0;
          wd_n    = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        wd_n = wd_q + WD_W'(1);
        if (bus.mem_complete) begin
          rdata_n = (op_q == OP_RD) ? bus.mem_dout : '0;
          err_n   = 1'b0;
          state_n = RESP;
        end else if (wd_exp) begin
          rdata_n = '0;
          err_n   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign done_vec      = (state_q == RESP) ? (NUM_REQ'(1) << id_q) : '0;

  assign bus.req_done  = done_vec;
  assign bus.req_err   = err_q ? done_vec : '0;
  assign bus.req_rdata = (state_q == RESP) ? rdata_q : '0;
  assign bus.mem_rd    = (state_q == BUSY) && (op_q == OP_RD);
  assign bus.mem_wr    = (state_q == BUSY) && (op_q == OP_WR);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = wdata_q;
  assign bus.grant_id  = id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed vectors for lc3_mem_arbiter with two requesters and TIMEOUT_CYC=4.
// A table covers single transactions, and hand-written sequences cover reset, contention and mid-transaction reset.
module tb_lc3_mem_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lc3_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  lc3_mem_arbiter #(
    .NUM_REQ     (NR),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] w0;
    logic [15:0] w1;
    int          cdly;
    logic [15:0] dout;
    int          e_id;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_din;
    logic [15:0] e_rdata;
    logic        e_err;
    int          e_strobe;
  } vec_t;

  vec_t vecs [7];
  vec_t post_rst;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    bus.req_rd       = '0;
    bus.req_wr       = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.mem_dout     = '0;
    bus.mem_complete = 1'b0;
  endtask

  // The caller starts on a negedge in IDLE. Complete is driven in BUSY cycle number cdly (0-based).
  task automatic run_vec(input vec_t v, input string tag);
    int         strobes;
    int         n;
    logic       seen;
    logic [1:0] exp_done;
    strobes  = 0;
    seen     = 1'b0;
    exp_done = 2'b01 << v.e_id;
    bus.req_rd    = v.rd;
    bus.req_wr    = v.wr;
    bus.req_addr  = {v.a1, v.a0};
    bus.req_wdata = {v.w1, v.w0};
    tick;
    chk({tag, " busy"},     bus.busy,     1);
    chk({tag, " grant_id"}, bus.grant_id, v.e_id);
    chk({tag, " mem_rd"},   bus.mem_rd,   v.e_rd);
    chk({tag, " mem_wr"},   bus.mem_wr,   v.e_wr);
    chk({tag, " mem_addr"}, bus.mem_addr, v.e_addr);
    chk({tag, " mem_din"},  bus.mem_din,  v.e_din);
    for (n = 0; n < 20; n++) begin
      if (|bus.req_done) begin
        seen = 1'b1;
        break;
      end
      if (bus.mem_rd || bus.mem_wr) strobes++;
      bus.mem_complete = (n == v.cdly);
      bus.mem_dout     = (n == v.cdly) ? v.dout : 16'hDEAD;
      tick;
    end
    bus.mem_complete = 1'b0;
    bus.req_rd       = '0;
    bus.req_wr       = '0;
    chk({tag, " done_seen"}, seen,          1);
    chk({tag, " req_done"},  bus.req_done,  exp_done);
    chk({tag, " req_err"},   bus.req_err,   v.e_err ? exp_done : 2'b00);
    chk({tag, " req_rdata"}, bus.req_rdata, v.e_rdata);
    chk({tag, " strobes"},   strobes,       v.e_strobe);
    tick;
    chk({tag, " done_1cyc"}, bus.req_done,  0);
    chk({tag, " idle"},      bus.busy,      0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int         exp_g [3];
    int         n;
    logic [1:0] acc;

    vecs[0] = '{rd:2'b01, wr:2'b00, a0:16'h3000, a1:16'h0000, w0:16'h0000, w1:16'h0000, cdly:1,  dout:16'h1234,
                e_id:0, e_rd:1, e_wr:0, e_addr:16'h3000, e_din:16'h0000, e_rdata:16'h1234, e_err:0, e_strobe:2};
    vecs[1] = '{rd:2'b00, wr:2'b10, a0:16'h0000, a1:16'h4000, w0:16'h0000, w1:16'hBEEF, cdly:0,  dout:16'h5555,
                e_id:1, e_rd:0, e_wr:1, e_addr:16'h4000, e_din:16'hBEEF, e_rdata:16'h0000, e_err:0, e_strobe:1};
    vecs[2] = '{rd:2'b10, wr:2'b10, a0:16'h0000, a1:16'h1111, w0:16'h0000, w1:16'hAAAA, cdly:0,  dout:16'h7777,
                e_id:1, e_rd:1, e_wr:0, e_addr:16'h1111, e_din:16'hAAAA, e_rdata:16'h7777, e_err:0, e_strobe:1};
    vecs[3] = '{rd:2'b01, wr:2'b00, a0:16'h2222, a1:16'h0000, w0:16'h0000, w1:16'h0000, cdly:99, dout:16'h9999,
                e_id:0, e_rd:1, e_wr:0, e_addr:16'h2222, e_din:16'h0000, e_rdata:16'h0000, e_err:1, e_strobe:4};
    vecs[4] = '{rd:2'b10, wr:2'b00, a0:16'h0000, a1:16'h3333, w0:16'h0000, w1:16'h0000, cdly:3,  dout:16'hCAFE,
                e_id:1, e_rd:1, e_wr:0, e_addr:16'h3333, e_din:16'h0000, e_rdata:16'hCAFE, e_err:0, e_strobe:4};
    vecs[5] = '{rd:2'b00, wr:2'b01, a0:16'h5000, a1:16'h0000, w0:16'h1357, w1:16'h0000, cdly:99, dout:16'h8888,
                e_id:0, e_rd:0, e_wr:1, e_addr:16'h5000, e_din:16'h1357, e_rdata:16'h0000, e_err:1, e_strobe:4};
    vecs[6] = '{rd:2'b01, wr:2'b00, a0:16'hFFFF, a1:16'h0000, w0:16'h0000, w1:16'h0000, cdly:0,  dout:16'hFFFF,
                e_id:0, e_rd:1, e_wr:0, e_addr:16'hFFFF, e_din:16'h0000, e_rdata:16'hFFFF, e_err:0, e_strobe:1};
    post_rst = '{rd:2'b10, wr:2'b00, a0:16'h0000, a1:16'h6000, w0:16'h0000, w1:16'h0000, cdly:1, dout:16'h4242,
                 e_id:1, e_rd:1, e_wr:0, e_addr:16'h6000, e_din:16'h0000, e_rdata:16'h4242, e_err:0, e_strobe:2};
`ifdef LC3_MEMARB_RR_EN
    exp_g = '{0, 1, 0};
`else
    exp_g = '{0, 0, 0};
`endif

    // A request held during reset must not be granted.
    clear_inputs();
    @(negedge clk);
    bus.req_rd   = 2'b01;
    bus.req_addr = {16'h0000, 16'h1234};
    tick;
    tick;
    chk("rst mem_rd",    bus.mem_rd,    0);
    chk("rst mem_wr",    bus.mem_wr,    0);
    chk("rst mem_addr",  bus.mem_addr,  0);
    chk("rst mem_din",   bus.mem_din,   0);
    chk("rst req_done",  bus.req_done,  0);
    chk("rst req_err",   bus.req_err,   0);
    chk("rst req_rdata", bus.req_rdata, 0);
    chk("rst grant_id",  bus.grant_id,  0);
    chk("rst busy",      bus.busy,      0);
    clear_inputs();
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Contention with both reads held, starting from a fresh reset so the pointer is 0.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    bus.req_rd   = 2'b11;
    bus.req_addr = {16'h0B00, 16'h0A00};
    for (int t = 0; t < 3; t++) begin
      n = 0;
      while (!bus.busy && n < 10) begin
        tick;
        n++;
      end
      chk($sformatf("cont%0d grant_gap", t), n, 1);
      chk($sformatf("cont%0d grant_id", t), bus.grant_id, exp_g[t]);
      chk($sformatf("cont%0d mem_addr", t), bus.mem_addr, (exp_g[t] == 1) ? 16'h0B00 : 16'h0A00);
      bus.mem_complete = 1'b1;
      bus.mem_dout     = 16'h0100 + 16'(t);
      tick;
      bus.mem_complete = 1'b0;
      if (t == 2) bus.req_rd = 2'b00;
      chk($sformatf("cont%0d req_done", t), bus.req_done, 2'b01 << exp_g[t]);
      chk($sformatf("cont%0d req_rdata", t), bus.req_rdata, 16'h0100 + 16'(t));
      tick;
      chk($sformatf("cont%0d idle_gap", t), bus.busy, 0);
    end
    tick;
    chk("cont released", bus.busy, 0);

    // Reset in the middle of BUSY abandons the transaction.
    bus.req_rd   = 2'b10;
    bus.req_addr = {16'h6000, 16'h0000};
    tick;
    chk("mid busy",     bus.busy,     1);
    chk("mid grant_id", bus.grant_id, 1);
    chk("mid mem_rd",   bus.mem_rd,   1);
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    bus.req_rd = 2'b00;
    chk("mid rst mem_rd",   bus.mem_rd,   0);
    chk("mid rst busy",     bus.busy,     0);
    chk("mid rst grant_id", bus.grant_id, 0);
    acc = bus.req_done;
    for (int k = 0; k < 3; k++) begin
      tick;
      acc = acc | bus.req_done;
    end
    chk("mid rst no done", acc, 0);
    run_vec(post_rst, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
